// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight,
// and drives the IF/ID pipeline register toward decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HELD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] req_pc_q;
  logic [31:0] hold_inst_q;
  logic        req;
  logic        accept;
  logic        deliver;
  logic        capture;
  logic [31:0] dlv_inst;

  logic        unused_stall;
  assign unused_stall = ^stall_i[5:3];

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign accept      = req & imem_ready_i;

  // Request generation, next state, PC and drop bookkeeping
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    req      = 1'b0;
    deliver  = 1'b0;
    capture  = 1'b0;
    dlv_inst = imem_rdata_i;
    if (!rst && !flush_i) begin
      case (state_q)
        S_FETCH: req = ~stall_i[0];
        S_WAIT:  req = imem_rvalid_i & ~drop_q & ~stall_i[1];
        default: req = 1'b0;
      endcase
    end
    if (flush_i) begin
      pc_d    = new_pc_i;
      state_d = S_FETCH;
      drop_d  = (state_q == S_WAIT) & ~imem_rvalid_i;
    end else begin
      case (state_q)
        S_FETCH: begin
          // a stale response landing after a redirect is swallowed here
          if (drop_q && imem_rvalid_i) drop_d = 1'b0;
          if (accept) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_FETCH;
            end else if (stall_i[1]) begin
              capture = 1'b1;
              state_d = S_HELD;
            end else begin
              deliver = 1'b1;
              if (accept) begin
                pc_d    = pc_q + 32'd4;
                state_d = S_WAIT;
              end else begin
                state_d = S_FETCH;
              end
            end
          end
        end
        S_HELD: begin
          if (!stall_i[1]) begin
            deliver  = 1'b1;
            dlv_inst = hold_inst_q;
            state_d  = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State, PC and drop registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  // PC of the in-flight request and the stalled-response buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_q    <= 32'd0;
      hold_inst_q <= NOP_INST;
    end else begin
      if (accept) req_pc_q <= pc_q;
      if (capture) hold_inst_q <= imem_rdata_i;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_o <= 1'b0;
      id_inst_o  <= NOP_INST;
      id_pc_o    <= 32'd0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
      id_inst_o  <= NOP_INST;
    end else if (stall_i[2]) begin
      id_valid_o <= id_valid_o;
    end else if (stall_i[1]) begin
      id_valid_o <= 1'b0;
      id_inst_o  <= NOP_INST;
    end else if (deliver) begin
      id_valid_o <= 1'b1;
      id_inst_o  <= dlv_inst;
      id_pc_o    <= req_pc_q;
    end else begin
      id_valid_o <= 1'b0;
      id_inst_o  <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a single-outstanding memory model
// whose response word is addr ^ 32'hA5A5_0000.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall = 6'd0;
  logic        flush = 1'b0;
  logic [31:0] new_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        mem_rv = 1'b0;
  logic [31:0] mem_rd = 32'd0;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int n_chk = 0;
  int n_fail = 0;
  int lat = 1;
  int cnt = 0;
  logic [31:0] paddr = 32'd0;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .new_pc_i      (new_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ready_i  (imem_ready),
    .imem_rvalid_i (mem_rv),
    .imem_rdata_i  (mem_rd),
    .pc_o          (pc),
    .id_pc_o       (id_pc),
    .id_inst_o     (id_inst),
    .id_valid_o    (id_valid)
  );

  always #5 clk = ~clk;

  assign imem_ready = (cnt == 0);

  // Memory: accepts when idle, answers lat cycles after acceptance
  always @(posedge clk) begin
    logic        acc;
    logic [31:0] a;
    acc = imem_req & imem_ready;
    a   = imem_addr;
    #1;
    mem_rv = 1'b0;
    if (acc) begin
      cnt   = lat;
      paddr = a;
    end
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        mem_rv = 1'b1;
        mem_rd = paddr ^ KEY;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_inst", id_inst, NOP);
    chk("rst_idpc", id_pc, 32'd0);

    // zero-wait streaming
    lat = 1;
    do_reset();
    chk("zw_req0", {31'd0, imem_req}, 32'd1);
    chk("zw_addr0", imem_addr, 32'd0);
    @(negedge clk);
    chk("zw_addr1", imem_addr, 32'd4);
    chk("zw_v1", {31'd0, id_valid}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("zw_valid", {31'd0, id_valid}, 32'd1);
      chk("zw_idpc", id_pc, 32'(4 * i));
      chk("zw_inst", id_inst, 32'(4 * i) ^ KEY);
      chk("zw_pc", pc, 32'(4 * i + 8));
    end

    // four cycles per instruction
    lat = 4;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("sl_req", {31'd0, imem_req}, {31'd0, (k % 4 == 0)});
      chk("sl_valid", {31'd0, id_valid},
          {31'd0, (k % 4 == 1) && (k >= 5)});
      if (k == 5) chk("sl_pc0", id_pc, 32'd0);
      if (k == 9) chk("sl_pc1", id_pc, 32'd4);
    end

    // stall while response arrives
    lat = 1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    chk("st_v0", {31'd0, id_valid}, 32'd1);
    stall = 6'b000111;
    #1;
    chk("st_req_off", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("st_hold_v", {31'd0, id_valid}, 32'd1);
      chk("st_hold_pc", id_pc, 32'd0);
      chk("st_hold_in", id_inst, KEY);
      chk("st_pcfrz", pc, 32'd8);
      chk("st_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 6'd0;
    #1;
    chk("st_rel_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("st_buf_v", {31'd0, id_valid}, 32'd1);
    chk("st_buf_pc", id_pc, 32'd4);
    chk("st_buf_in", id_inst, 32'd4 ^ KEY);
    chk("st_nxt_req", {31'd0, imem_req}, 32'd1);
    chk("st_nxt_adr", imem_addr, 32'd8);
    @(negedge clk);
    chk("st_gap", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    chk("st_nxt_pc", id_pc, 32'd8);
    chk("st_nxt_v", {31'd0, id_valid}, 32'd1);

    // flush during outstanding request, 2-cycle latency
    lat = 2;
    do_reset();
    @(negedge clk);
    flush = 1'b1;
    new_pc = 32'h100;
    #1;
    chk("fl_req_off", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_req", {31'd0, imem_req}, 32'd1);
    chk("fl_addr", imem_addr, 32'h100);
    chk("fl_v2", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    chk("fl_v3", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    chk("fl_v4", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    chk("fl_v5", {31'd0, id_valid}, 32'd1);
    chk("fl_idpc", id_pc, 32'h100);
    chk("fl_inst", id_inst, 32'h100 ^ KEY);

    // flush and stall together, then PC wrap, then reset mid-wait
    lat = 1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    chk("fs_pc", pc, 32'd8);
    flush = 1'b1;
    new_pc = 32'h200;
    stall = 6'b001111;
    #1;
    chk("fs_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("fs_v", {31'd0, id_valid}, 32'd0);
    chk("fs_inst", id_inst, NOP);
    chk("fs_newpc", pc, 32'h200);
    flush = 1'b0;
    stall = 6'd0;
    #1;
    chk("fs_addr", imem_addr, 32'h200);
    @(negedge clk);
    @(negedge clk);
    chk("fs_idpc", id_pc, 32'h200);
    chk("fs_idv", {31'd0, id_valid}, 32'd1);
    flush = 1'b1;
    new_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wr_v", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    chk("wr_pc", pc, 32'd0);
    lat = 3;
    @(negedge clk);
    chk("wr_idpc", id_pc, 32'hFFFF_FFFC);
    chk("wr_inst", id_inst, 32'h5A5A_FFFC);
    chk("wr_pc4", pc, 32'd4);
    rst = 1'b1;
    #1;
    chk("rr_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("rr_pc", pc, 32'd0);
    chk("rr_v", {31'd0, id_valid}, 32'd0);
    chk("rr_inst", id_inst, NOP);
    chk("rr_idpc", id_pc, 32'd0);
    rst = 1'b0;
    #1;
    chk("rr_req1", {31'd0, imem_req}, 32'd1);
    chk("rr_adr1", imem_addr, 32'd0);
    @(negedge clk);
    chk("rr_stray_v", {31'd0, id_valid}, 32'd0);
    @(negedge clk);
    chk("rr_stray_v2", {31'd0, id_valid}, 32'd0);
    chk("rr_stray_i", id_inst, NOP);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rr_first_v", {31'd0, id_valid}, 32'd1);
    chk("rr_first_pc", id_pc, 32'd0);
    chk("rr_first_in", id_inst, KEY);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the RISC-V pipeline. It sits directly downstream of the pipeline controller and consumes its `stall[5:0]`, `flush` and `new_pc` outputs. It owns the PC and issues one outstanding request at a time to the instruction memory port. It then presents the fetched instruction, or a bubble, to the decode stage.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `NOP_INST`, default `32'h0000_0013`: bubble instruction (`addi x0,x0,0`).

Ports:
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset. Synchronous, active-high.
- `stall_i`, input, 6: controller stall vector. Bit 0 = PC hold, bit 1 = IF hold, bit 2 = ID hold; bits 5:3 are ignored.
- `flush_i`, input, 1: redirect fetch to `new_pc_i` and kill the instruction in IF/ID.
- `new_pc_i`, input, 32: redirect target. Only meaningful while `flush_i=1`.
- `imem_req_o`, output, 1: instruction memory request.
- `imem_addr_o`, output, 32: request address. Always equal to `pc_o`.
- `imem_ready_i`, input, 1: request accepted in the current cycle when `imem_req_o=1`.
- `imem_rvalid_i`, input, 1: response valid. Arrives one or more cycles after acceptance.
- `imem_rdata_i`, input, 32: response instruction.
- `pc_o`, output, 32: next fetch address.
- `id_pc_o`, output, 32: PC of the instruction in IF/ID.
- `id_inst_o`, output, 32: instruction in IF/ID.
- `id_valid_o`, output, 1: IF/ID holds a real instruction.

## Operation
- The FSM has three states.
  - FETCH: request is issued.
  - WAIT: request accepted, response outstanding.
  - HELD: response captured while IF is stalled.
- `drop` flag: set when the outstanding response must be discarded.
- `imem_req_o` = (FETCH & ~stall_i[0]) | (WAIT & imem_rvalid_i & ~drop & ~stall_i[1]). It is forced to 0 when `flush_i` or `rst` is high.
- FETCH state:
  - If `imem_req_o & imem_ready_i`: `pc <= pc+4`, go to WAIT.
  - Otherwise stay in FETCH; `pc` holds.
- WAIT state, on `imem_rvalid_i`:
  - If `drop`: discard the response, clear `drop`, go to FETCH.
  - Else if `stall_i[1]`: capture `{pc_of_req, rdata}` into the holding buffer, go to HELD.
  - Else: deliver to IF/ID. Then follow the FETCH rules for the back-to-back request: go to WAIT and `pc+4` if accepted, otherwise FETCH.
- HELD state: when `stall_i[1]=0`, deliver the buffer to IF/ID and go to FETCH. No request is issued that cycle.
- Requested-PC register: latches `pc` on every accepted request. It supplies `id_pc_o`.
- Flush (highest priority after reset):
  - `pc <= new_pc_i`.
  - IF/ID becomes a bubble.
  - State goes to FETCH; the holding buffer is invalidated.
  - If in WAIT with no `imem_rvalid_i` this cycle, set `drop`.
  - A response arriving in the flush cycle is discarded.
- IF/ID update priority:
  1. `rst`: valid=0, inst=NOP_INST, pc=0.
  2. `flush_i`: bubble.
  3. `stall_i[2]`: hold.
  4. `stall_i[1]` with `~stall_i[2]`: bubble.
  5. Deliver: valid=1, load pc and inst.
  6. Otherwise: bubble.
- Bubble definition: valid=0, inst=NOP_INST, pc unchanged.
- `stall_i[0]` blocks new requests and PC increment. It does not abort an outstanding request.
- PC arithmetic: 32-bit modulo. `32'hFFFF_FFFC + 4` wraps to 0. Misalignment is not checked.

## Timing
- Reset values:
  - `pc_o` = RESET_PC.
  - State = FETCH, `drop`=0, `imem_req_o`=0 during the reset cycle.
  - `id_valid_o`=0, `id_inst_o`=NOP_INST, `id_pc_o`=0.
- First request is issued in the first cycle after `rst` deasserts.
- With zero-wait memory (ready same cycle as req, rvalid next cycle), throughput is one instruction per cycle.
- Latency: IF/ID is loaded at the edge where `imem_rvalid_i` is seen. The instruction is visible on `id_*` the cycle after rvalid.
- Flush redirect: `new_pc_i` appears on `imem_addr_o` the cycle after `flush_i`. A flush lasting multiple cycles reloads `pc` each cycle.
- Reset mid-request clears `drop`. A late response after reset is ignored because state is FETCH.
- Flush and stall in the same cycle: flush wins.

## Test plan
- Reset, then zero-wait memory returning `addr^32'hA5A5_0000`:
  - Requests go to 0, 4, 8, … in consecutive cycles.
  - `id_valid_o`=1 continuously from cycle 2.
  - `id_pc_o` is 0, 4, 8, …
- 3-cycle memory latency: `imem_req_o` is high one cycle per instruction. `id_valid_o` pulses once every 4 cycles; it is 0 (NOP) between pulses.
- Stall `6'b000111` held 3 cycles while a response arrives:
  - IF/ID holds its instruction and `pc_o` is frozen.
  - State goes to HELD.
  - On release, the buffered instruction appears on `id_*` with its correct PC; the next request follows one cycle later.
- Flush to `32'h0000_0100` while WAIT is outstanding with 2-cycle latency:
  - The old response is dropped; `id_valid_o` stays 0.
  - The next request address is `0x100`; the first valid `id_pc_o` is `0x100`.
- Flush and stall `6'b001111` asserted in the same cycle: IF/ID becomes a bubble, `pc_o`=`new_pc_i` next cycle.
- PC at `32'hFFFF_FFFC` with an accepted request: the next `pc_o` is `32'h0000_0000`. Asserting `rst` mid-WAIT: all outputs return to their reset values next cycle, and the subsequent stray rvalid is ignored.
